mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Byte-serial memory controller between the pipeline and the 8-bit RAM/IO bus.
- Serves two requesters:
  - the IF stage: 32-bit instruction fetch;
  - the MEM stage: byte, half or word load/store.
- Serialises each transfer into little-endian byte accesses.
- Arbitrates MEM over IF and returns assembled data with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, width of all address ports.
- IO_TAG, 2'b11, value of addr[17:16] marking the IO region (informational; no special sequencing beyond the single-byte rule below).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  ready; when low all state freezes.
- if_req  in  1  fetch request; level, held until if_done or cancel.
- if_addr  in  ADDR_W  fetch address.
- if_cancel  in  1  branch flush; aborts an in-flight fetch.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched instruction.
- mem_req  in  1  load/store request; level, held until mem_done.
- mem_we  in  1  1 = store.
- mem_size  in  2  00 byte, 01 half, 10/11 word.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  32  store data, bytes taken from LSB upward.
- mem_done  out  1  one-cycle pulse; mem_rdata valid.
- mem_rdata  out  32  load data, zero-extended (MEM stage sign-extends).
- ram_din  in  8  bus read data.
- ram_dout  out  8  bus write data.
- ram_a  out  ADDR_W  bus address.
- ram_wr  out  1  1 = write.
- busy  out  1  high in any state except IDLE.

Behaviour:
- All outputs registered. Reset (rst=0, async) forces:
  - state IDLE;
  - if_done, mem_done, ram_wr, busy = 0;
  - ram_a, ram_dout, if_data, mem_rdata = 0.
- rdy=0: every register holds; no request accepted; no byte counted. Resume continues exactly where frozen.
- Bus timing: the address on ram_a in cycle c returns data on ram_din in cycle c+1. A write completes in the cycle ram_wr=1.
- States:
  - IDLE: samples requests. mem_req wins over if_req when both are high. Accepting latches addr, size (IF = word), we, wdata, and owner. The first byte address is driven to ram_a at the accept edge.
  - READ: bytes k=0..N-1 addressed in consecutive cycles at addr+k. Byte k is captured into bits [8k+7:8k] one cycle after its address. After the last capture, the owner's done pulses and the state goes to DONE.
    - N-byte read: done is high in the cycle following the (N+1)th edge after the accept edge.
    - Word fetch: accept edge to done-visible is 5 cycles.
  - WRITE: byte k placed on ram_dout with ram_a=addr+k and ram_wr=1, one byte per cycle. After byte N-1, mem_done pulses (N edges after accept) and the state goes to DONE.
  - DONE: exactly one cycle, in which done is high. ram_wr=0, ram_a=0, no request accepted. The state then returns to IDLE.
- Unused upper bits of mem_rdata are 0.
- ram_a and ram_dout are 0 whenever idle; ram_wr is 0 outside WRITE.
- if_cancel while an IF read is in flight: abort at the next edge. No if_done; the state goes to IDLE (not DONE); the partial if_data is discarded.
- if_cancel in IDLE blocks acceptance of if_req that edge.
- if_cancel in DONE or during a MEM transfer is ignored.
- A MEM transfer is never aborted or pre-empted. A pending if_req waits.
- Each byte address is issued exactly once per transfer; reads are never replayed. This makes IO reads such as 0x30000 side-effect safe.
- Addresses wrap modulo 2^ADDR_W; there is no alignment check.
- A requester dropping req mid-transfer has no effect; the transfer completes.

Test Plan:
- Reset mid-WRITE: assert rst=0 during byte 1 of a word store → ram_wr=0 and busy=0 immediately; after release, an if_req at 0x0 is served normally.
- Word fetch: if_req, if_addr=0x1000, RAM bytes 13,05,00,00 → ram_a 0x1000..0x1003 on consecutive cycles; if_data=0x00000513; if_done high 5 cycles after accept for one cycle; no accept in the DONE cycle.
- Simultaneous requests: if_req@0x2000 and mem_req load-half@0x3002 (bytes 0xFF,0x80) in the same cycle → MEM served first, mem_rdata=0x000080FF; IF accepted after DONE.
- Store word 0xDEADBEEF@0x4000 → ram_wr=1 for 4 cycles with ram_dout EF,BE,AD,DE at 0x4000..0x4003; mem_done 4 edges after accept.
- if_cancel after 2 bytes of a fetch → no if_done; IDLE next edge; a subsequent if_req@0x0100 fetches correctly.
- rdy held low 3 cycles mid-load → ram_a, counters and partial data frozen; final mem_rdata is identical to the no-stall run; latency grows by exactly 3.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial IF/MEM arbiter onto an 8-bit RAM/IO bus
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_TAG = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // The IO region sits at addr[17:16]; it needs no sequencing of its own
    // because no byte address is ever issued twice within a transfer.
    if (ADDR_W < 18 && IO_TAG != 2'b00) begin : g_io_tag_unreachable
    end

    state_t            state, state_nx;
    logic              owner_mem, owner_mem_nx;   // 1: MEM stage owns the transfer
    logic [ADDR_W-1:0] base, base_nx;
    logic [2:0]        nbytes, nbytes_nx;
    logic [2:0]        cnt, cnt_nx;               // active edges spent in READ/WRITE
    logic [31:0]       data_q, data_nx;           // read assembly or store data
    logic [ADDR_W-1:0] ram_a_nx;
    logic [7:0]        ram_dout_nx;
    logic              ram_wr_nx, if_done_nx, mem_done_nx, busy_nx;
    logic [31:0]       if_data_nx, mem_rdata_nx;
    logic [2:0]        cnt_p1;
    logic [1:0]        cap_idx;
    logic [31:0]       merged;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Next-state and next-output computation; everything holds while rdy is low.
    always_comb begin
        state_nx     = state;
        owner_mem_nx = owner_mem;
        base_nx      = base;
        nbytes_nx    = nbytes;
        cnt_nx       = cnt;
        data_nx      = data_q;
        ram_a_nx     = ram_a;
        ram_dout_nx  = ram_dout;
        ram_wr_nx    = ram_wr;
        if_done_nx   = if_done;
        mem_done_nx  = mem_done;
        if_data_nx   = if_data;
        mem_rdata_nx = mem_rdata;
        cnt_p1       = cnt + 3'd1;
        cap_idx      = 2'(cnt - 3'd1);
        merged       = data_q;
        merged[{cap_idx, 3'b000} +: 8] = ram_din;

        if (rdy) begin
            ram_wr_nx   = 1'b0;
            if_done_nx  = 1'b0;
            mem_done_nx = 1'b0;
            case (state)
                IDLE: begin
                    ram_a_nx    = '0;
                    ram_dout_nx = '0;
                    cnt_nx      = '0;
                    if (mem_req) begin
                        owner_mem_nx = 1'b1;
                        base_nx      = mem_addr;
                        nbytes_nx    = size_bytes(mem_size);
                        ram_a_nx     = mem_addr;
                        if (mem_we) begin
                            state_nx    = WRITE;
                            data_nx     = mem_wdata;
                            ram_dout_nx = mem_wdata[7:0];
                            ram_wr_nx   = 1'b1;
                        end else begin
                            state_nx = READ;
                            data_nx  = '0;
                        end
                    end else if (if_req && !if_cancel) begin
                        owner_mem_nx = 1'b0;
                        base_nx      = if_addr;
                        nbytes_nx    = 3'd4;
                        ram_a_nx     = if_addr;
                        state_nx     = READ;
                        data_nx      = '0;
                    end
                end
                READ: begin
                    if (!owner_mem && if_cancel) begin
                        state_nx = IDLE;
                        ram_a_nx = '0;
                        cnt_nx   = '0;
                    end else if (cnt == nbytes) begin
                        state_nx = DONE;
                        ram_a_nx = '0;
                        data_nx  = merged;
                        if (owner_mem) begin
                            mem_rdata_nx = merged;
                            mem_done_nx  = 1'b1;
                        end else begin
                            if_data_nx = merged;
                            if_done_nx = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt_p1;
                        if (cnt != 3'd0)
                            data_nx = merged;
                        ram_a_nx = (cnt_p1 < nbytes) ? base + ADDR_W'(cnt_p1) : '0;
                    end
                end
                WRITE: begin
                    if (cnt_p1 < nbytes) begin
                        cnt_nx      = cnt_p1;
                        ram_a_nx    = base + ADDR_W'(cnt_p1);
                        ram_dout_nx = data_q[{cnt_p1[1:0], 3'b000} +: 8];
                        ram_wr_nx   = 1'b1;
                    end else begin
                        state_nx    = DONE;
                        ram_a_nx    = '0;
                        ram_dout_nx = '0;
                        mem_done_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx    = IDLE;
                    ram_a_nx    = '0;
                    ram_dout_nx = '0;
                end
            endcase
        end
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner_mem <= 1'b0;
            base      <= '0;
            nbytes    <= '0;
            cnt       <= '0;
            data_q    <= '0;
            ram_a     <= '0;
            ram_dout  <= '0;
            ram_wr    <= 1'b0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            owner_mem <= owner_mem_nx;
            base      <= base_nx;
            nbytes    <= nbytes_nx;
            cnt       <= cnt_nx;
            data_q    <= data_nx;
            ram_a     <= ram_a_nx;
            ram_dout  <= ram_dout_nx;
            ram_wr    <= ram_wr_nx;
            if_done   <= if_done_nx;
            mem_done  <= mem_done_nx;
            if_data   <= if_data_nx;
            mem_rdata <= mem_rdata_nx;
            busy      <= busy_nx;
        end
    end

endmodule
